mux41_rr_arb: RTL and testbench

Round-robin arbiter that shares a single 4:1 one-bit mux between four requesters (a, b, c, d). It owns the mux select lines {s0,s1} and issues a registered one-hot grant. A hold limit ensures that no requester can monopolise the mux while others are waiting. It sits directly in front of the 4:1 mux, and each requester's data bit feeds the matching mux input.

---
 rtl/mux41_rr_arb.sv | 106 ++++++++++
 tb/tb_mux41_rr_arb.sv | 130 +++++++++++++
 2 files changed

// File: rtl/mux41_rr_arb.sv
// mux41_rr_arb: round-robin arbiter that owns the select lines of a shared
// 4:1 one-bit mux. It issues a one-hot grant to one of four requesters.
// A hold limit forces a handover when others are waiting.
//
// state | meaning
// IDLE  | no grant active; select lines hold the last granted index
// BUSY  | owner holds the mux; gnt = onehot(owner)
module mux41_rr_arb #(
    parameter int MAX_HOLD = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] req,
    output logic [3:0] gnt,
    output logic       s0,
    output logic       s1,
    output logic       busy
);

    typedef enum logic {IDLE, BUSY} state_t;

    localparam logic [3:0] HOLD_MAX = 4'(MAX_HOLD);

    state_t     state, state_nx;
    logic [1:0] owner, owner_nx;
    logic [1:0] last, last_nx;
    logic [3:0] cnt, cnt_nx;

    logic [3:0] cand;
    logic       found;
    logic [1:0] win;

    // Round-robin pick: first set bit of vec, starting at ptr+1 and wrapping
    // to ptr itself. Returns {found, index}.
    function automatic logic [2:0] rr_pick(input logic [3:0] vec, input logic [1:0] ptr);
        logic [2:0] res;
        logic [1:0] idx;
        res = 3'b000;
        for (int i = 4; i >= 1; i--) begin
            idx = ptr + 2'(i);
            if (vec[idx]) begin
                res = {1'b1, idx};
            end
        end
        return res;
    endfunction

    // State and arbitration registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            owner <= 2'd0;
            last  <= 2'd3;
            cnt   <= 4'd0;
        end else begin
            state <= state_nx;
            owner <= owner_nx;
            last  <= last_nx;
            cnt   <= cnt_nx;
        end
    end

    // Next-state: the current owner is masked out of the search while BUSY,
    // which covers both release and preemption with one search.
    always_comb begin
        state_nx = state;
        owner_nx = owner;
        last_nx  = last;
        cnt_nx   = cnt;
        cand     = (state == BUSY) ? (req & ~(4'b0001 << owner)) : req;
        {found, win} = rr_pick(cand, last);
        case (state)
            IDLE: begin
                if (found) begin
                    state_nx = BUSY;
                    owner_nx = win;
                    last_nx  = win;
                    cnt_nx   = 4'd1;
                end
            end
            BUSY: begin
                if (!req[owner] || (cnt == HOLD_MAX && found)) begin
                    if (found) begin
                        owner_nx = win;
                        last_nx  = win;
                        cnt_nx   = 4'd1;
                    end else begin
                        state_nx = IDLE;
                        cnt_nx   = 4'd0;
                    end
                end else if (cnt != HOLD_MAX) begin
                    cnt_nx = cnt + 4'd1;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // Outputs decode only registered state, so they change only at clock edges
    always_comb begin
        gnt      = (state == BUSY) ? (4'b0001 << owner) : 4'b0000;
        busy     = (state == BUSY);
        {s0, s1} = owner;
    end

endmodule

// File: tb/tb_mux41_rr_arb.sv
// Directed bench for mux41_rr_arb with MAX_HOLD = 4.
module tb_mux41_rr_arb;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] req;
    logic [3:0] gnt;
    logic       s0, s1, busy;

    int total = 0;
    int bad   = 0;

    mux41_rr_arb #(.MAX_HOLD(4)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .req  (req),
        .gnt  (gnt),
        .s0   (s0),
        .s1   (s1),
        .busy (busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Compares {gnt, s0, s1, busy} against the expected grant and select
    task automatic check(input string tag, input logic [3:0] eg, input logic [1:0] es);
        logic [6:0] obs, exp_v;
        obs   = {gnt, s0, s1, busy};
        exp_v = {eg, es, (eg != 4'b0000)};
        total++;
        assert (obs === exp_v) else begin
            bad++;
            $error("FAIL %s: gnt/s0s1/busy observed=%b_%b_%b expected=%b_%b_%b",
                   tag, obs[6:3], obs[2:1], obs[0], exp_v[6:3], exp_v[2:1], exp_v[0]);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        req   = 4'b1111;
        tick();
        tick();
        check("reset", 4'b0000, 2'b00);

        // Rotation under contention: each requester holds for exactly 4 cycles
        rst_n = 1'b1;
        for (int k = 0; k < 20; k++) begin
            tick();
            check($sformatf("rotate_%0d", k), 4'b0001 << ((k / 4) % 4), 2'((k / 4) % 4));
        end

        // Lone owner at the hold limit keeps the grant
        req = 4'b0001;
        tick();
        check("lone_at_limit", 4'b0001, 2'b00);

        // Gap-free handover a -> d
        req = 4'b1000;
        tick();
        check("handover_a_d", 4'b1000, 2'b11);

        // Release to idle, select holds last index
        req = 4'b0000;
        tick();
        check("idle_keeps_sel_d", 4'b0000, 2'b11);

        // Lone requester c for 10 cycles
        req = 4'b0100;
        for (int k = 0; k < 10; k++) begin
            tick();
            check($sformatf("lone_c_%0d", k), 4'b0100, 2'b10);
        end
        req = 4'b0000;
        tick();
        check("idle_keeps_sel_c", 4'b0000, 2'b10);

        // Search from last = c: order d, a, b, c -> b wins over c
        req = 4'b0110;
        tick();
        check("search_from_c", 4'b0010, 2'b01);
        req = 4'b0100;
        tick();
        check("release_b_to_c", 4'b0100, 2'b10);
        req = 4'b0000;
        tick();
        check("idle_after_c", 4'b0000, 2'b10);

        // New request while busy does not disturb the owner until preemption
        req = 4'b0001;
        tick();
        check("grant_a", 4'b0001, 2'b00);
        req = 4'b1001;
        for (int k = 0; k < 3; k++) begin
            tick();
            check($sformatf("a_holds_%0d", k), 4'b0001, 2'b00);
        end
        tick();
        check("preempt_a_to_d", 4'b1000, 2'b11);
        for (int k = 0; k < 3; k++) begin
            tick();
            check($sformatf("d_holds_%0d", k), 4'b1000, 2'b11);
        end
        tick();
        check("preempt_d_to_a", 4'b0001, 2'b00);

        // Reset mid-grant: owner d at cnt = 3
        req = 4'b1000;
        tick();
        check("release_a_to_d", 4'b1000, 2'b11);
        tick();
        tick();
        check("d_cnt3", 4'b1000, 2'b11);
        rst_n = 1'b0;
        req   = 4'b1111;
        tick();
        check("reset_mid_grant", 4'b0000, 2'b00);
        rst_n = 1'b1;
        tick();
        check("restart_from_a", 4'b0001, 2'b00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
